// File: rtl/writeback_unit_pkg.sv
// Shared parameters and types for the register-file writeback arbiter.
// Holds register-file geometry and the deferred-ALU FIFO entry format.
package writeback_unit_pkg;

    localparam int REGFILE_ADDR_BITS = 4;
    localparam int DATA_BUS_WIDTH    = 24;
    localparam int NUM_REGISTERS     = 16;
    localparam int WB_FIFO_DEPTH     = 4;   // power of two, at least 2

    localparam int FIFO_PTR_BITS = $clog2(WB_FIFO_DEPTH);
    localparam int FIFO_CNT_BITS = $clog2(WB_FIFO_DEPTH + 1);
    localparam logic [FIFO_CNT_BITS-1:0] FIFO_FULL_COUNT = FIFO_CNT_BITS'(WB_FIFO_DEPTH);

    typedef logic [REGFILE_ADDR_BITS-1:0] reg_addr_t;
    typedef logic [DATA_BUS_WIDTH-1:0]    reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_LOAD,
        WB_SRC_FIFO,
        WB_SRC_ALU
    } wb_src_e;

endpackage

// File: rtl/writeback_unit_wb_fifo.sv
// Deferred-ALU FIFO: holds {addr, data} results that lost the write port,
// and reports which valid entries target each hazard-query register.
module wb_fifo
    import writeback_unit_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    output wb_entry_t                    head,
    output logic [FIFO_CNT_BITS-1:0]     count,
    input  logic [REGFILE_ADDR_BITS-1:0] query_addr1,
    input  logic [REGFILE_ADDR_BITS-1:0] query_addr2,
    output logic [WB_FIFO_DEPTH-1:0]     match1,
    output logic [WB_FIFO_DEPTH-1:0]     match2
);

    wb_entry_t                  mem [WB_FIFO_DEPTH];
    logic [WB_FIFO_DEPTH-1:0]   valid;
    logic [FIFO_PTR_BITS-1:0]   rd_ptr;
    logic [FIFO_PTR_BITS-1:0]   wr_ptr;

    // NOTE: the storage array has no reset; per-entry valid bits and the
    // count are what make stale contents invisible after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            match1[i] = valid[i] && (mem[i].addr == query_addr1);
            match2[i] = valid[i] && (mem[i].addr == query_addr2);
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write-port arbiter: load returns beat the deferred-ALU FIFO,
// which beats direct ALU results. Also tracks outstanding loads for hazards.
module writeback_unit
    import writeback_unit_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    input  logic [REGFILE_ADDR_BITS-1:0] alu_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    alu_data,
    input  logic                         ld_issue_valid,
    input  logic [REGFILE_ADDR_BITS-1:0] ld_issue_addr,
    input  logic                         ld_done_valid,
    input  logic [REGFILE_ADDR_BITS-1:0] ld_done_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    ld_data,
    input  logic [REGFILE_ADDR_BITS-1:0] query_addr1,
    input  logic [REGFILE_ADDR_BITS-1:0] query_addr2,
    output logic                         busy1,
    output logic                         busy2,
    output logic                         stall,
    output logic                         overflow,
    output logic [REGFILE_ADDR_BITS-1:0] write_addr,
    output logic [DATA_BUS_WIDTH-1:0]    write_data,
    output logic                         write_enable
);

    logic [NUM_REGISTERS-1:0] pending;
    logic [NUM_REGISTERS-1:0] pending_next;
    logic [FIFO_CNT_BITS-1:0] fifo_count;
    logic [WB_FIFO_DEPTH-1:0] match1;
    logic [WB_FIFO_DEPTH-1:0] match2;
    wb_entry_t                fifo_head;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_empty;
    logic                     alu_take;
    wb_src_e                  src;

    wb_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .push_entry  ('{addr: alu_addr, data: alu_data}),
        .pop         (fifo_pop),
        .head        (fifo_head),
        .count       (fifo_count),
        .query_addr1 (query_addr1),
        .query_addr2 (query_addr2),
        .match1      (match1),
        .match2      (match2)
    );

    assign stall      = (fifo_count == FIFO_FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);
    // An accepted ALU result only matters if it targets a real register.
    assign alu_take   = alu_valid && !stall && (alu_addr != '0);

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        src       = WB_SRC_NONE;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (ld_done_valid) begin
            // A load to r0 still claims the slot, it just writes nothing.
            src       = (ld_done_addr != '0) ? WB_SRC_LOAD : WB_SRC_NONE;
            fifo_push = alu_take;
        end else if (!fifo_empty) begin
            src       = WB_SRC_FIFO;
            fifo_pop  = 1'b1;
            fifo_push = alu_take;
        end else if (alu_take) begin
            src       = WB_SRC_ALU;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= (src != WB_SRC_NONE);
            case (src)
                WB_SRC_LOAD: begin
                    write_addr <= ld_done_addr;
                    write_data <= ld_data;
                end
                WB_SRC_FIFO: begin
                    write_addr <= fifo_head.addr;
                    write_data <= fifo_head.data;
                end
                WB_SRC_ALU: begin
                    write_addr <= alu_addr;
                    write_data <= alu_data;
                end
                default: ;
            endcase
        end
    end

    // Clear first, then set, so an issue and a return to one register leave it pending.
    always_comb begin
        pending_next = pending;
        if (ld_done_valid) pending_next[ld_done_addr] = 1'b0;
        if (ld_issue_valid) pending_next[ld_issue_addr] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= pending_next;
            if (alu_valid && stall) overflow <= 1'b1;
        end
    end

    assign busy1 = (query_addr1 != '0) && (pending[query_addr1] || (|match1));
    assign busy2 = (query_addr2 != '0) && (pending[query_addr2] || (|match2));

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed scenarios then constrained-random
// traffic, checked against a queue-based model of the arbitration rules.
module tb_writeback_unit;
    import writeback_unit_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         alu_valid, ld_issue_valid, ld_done_valid;
    logic [REGFILE_ADDR_BITS-1:0] alu_addr, ld_issue_addr, ld_done_addr;
    logic [DATA_BUS_WIDTH-1:0]    alu_data, ld_data;
    logic [REGFILE_ADDR_BITS-1:0] query_addr1, query_addr2;
    logic                         busy1, busy2, stall, overflow, write_enable;
    logic [REGFILE_ADDR_BITS-1:0] write_addr;
    logic [DATA_BUS_WIDTH-1:0]    write_data;

    always #5 clk = ~clk;

    writeback_unit dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_addr  (ld_issue_addr),
        .ld_done_valid  (ld_done_valid),
        .ld_done_addr   (ld_done_addr),
        .ld_data        (ld_data),
        .query_addr1    (query_addr1),
        .query_addr2    (query_addr2),
        .busy1          (busy1),
        .busy2          (busy2),
        .stall          (stall),
        .overflow       (overflow),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .write_enable   (write_enable)
    );

    typedef struct { int cyc; int addr; int data; } exp_t;
    typedef struct { int addr; int data; } def_t;

    exp_t exp_q[$];                 // expected register-file writes, in order
    def_t defq[$];                  // model of deferred ALU results
    bit   pend[NUM_REGISTERS];      // model of outstanding loads
    bit   m_overflow;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   h_addr = 0;
    int   h_data = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, actual, expected);
        end
    endtask

    function automatic bit m_busy(input int a);
        if (a == 0) return 1'b0;
        if (pend[a]) return 1'b1;
        foreach (defq[i]) if (defq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock of behaviour: which write reaches the register file, what gets deferred.
    task automatic model_step(input bit alu_v, input int alu_a, input int alu_d,
                              input bit li_v, input int li_a,
                              input bit ld_v, input int ld_a, input int ld_d);
        bit   full;
        bit   acc;
        def_t e;
        full = (defq.size() == WB_FIFO_DEPTH);
        acc  = alu_v && !full && (alu_a != 0);
        if (alu_v && full) m_overflow = 1'b1;
        if (ld_v) begin
            if (ld_a != 0) exp_q.push_back('{cyc + 1, ld_a, ld_d});
            if (acc) defq.push_back('{alu_a, alu_d});
        end else if (defq.size() > 0) begin
            e = defq.pop_front();
            exp_q.push_back('{cyc + 1, e.addr, e.data});
            if (acc) defq.push_back('{alu_a, alu_d});
        end else if (acc) begin
            exp_q.push_back('{cyc + 1, alu_a, alu_d});
        end
        if (ld_v) pend[ld_a] = 1'b0;
        if (li_v) pend[li_a] = 1'b1;
        pend[0] = 1'b0;
    endtask

    task automatic step(input bit alu_v, input int alu_a, input int alu_d,
                        input bit li_v, input int li_a,
                        input bit ld_v, input int ld_a, input int ld_d, input int q1);
        @(negedge clk);
        #1;
        alu_valid      = alu_v;
        alu_addr       = reg_addr_t'(alu_a);
        alu_data       = reg_data_t'(alu_d);
        ld_issue_valid = li_v;
        ld_issue_addr  = reg_addr_t'(li_a);
        ld_done_valid  = ld_v;
        ld_done_addr   = reg_addr_t'(ld_a);
        ld_data        = reg_data_t'(ld_d);
        query_addr1    = reg_addr_t'(q1);
        query_addr2    = reg_addr_t'($urandom_range(0, NUM_REGISTERS - 1));
        #1;
        check("busy1", busy1, m_busy(q1));
        check("busy2", busy2, m_busy(int'(query_addr2)));
        check("stall", stall, defq.size() == WB_FIFO_DEPTH);
        check("overflow", overflow, m_overflow);
        model_step(alu_v, alu_a, alu_d & 'hFFFFFF, li_v, li_a, ld_v, ld_a, ld_d & 'hFFFFFF);
    endtask

    task automatic idle(input int n, input int q1);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, q1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        {alu_valid, ld_issue_valid, ld_done_valid} = '0;
        query_addr1 = 4'd7;
        query_addr2 = 4'd3;
        #1;
        check("rst_write_enable", write_enable, 0);
        check("rst_write_addr", write_addr, 0);
        check("rst_write_data", write_data, 0);
        check("rst_stall", stall, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy1", busy1, 0);
        check("rst_busy2", busy2, 0);
        defq.delete();
        exp_q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        m_overflow = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic int pick_free();
        int a;
        for (int t = 0; t < 8; t++) begin
            a = $urandom_range(0, NUM_REGISTERS - 1);
            if (!m_busy(a)) return a;
        end
        return 0;
    endfunction

    task automatic rand_cycle();
        bit alu_v, li_v, ld_v;
        int alu_a, li_a, ld_a;
        int plist[$];
        alu_v = 0; li_v = 0; ld_v = 0; alu_a = 0; li_a = 0; ld_a = 0;
        if (defq.size() < WB_FIFO_DEPTH && $urandom_range(0, 99) < 55) begin
            alu_v = 1;
            alu_a = pick_free();
        end
        for (int r = 1; r < NUM_REGISTERS; r++) if (pend[r]) plist.push_back(r);
        if (plist.size() > 0 && $urandom_range(0, 99) < 35) begin
            ld_v = 1;
            ld_a = plist[$urandom_range(0, plist.size() - 1)];
        end else if ($urandom_range(0, 99) < 3) begin
            ld_v = 1;
        end
        if ($urandom_range(0, 99) < 30) begin
            li_a = pick_free();
            li_v = !(alu_v && li_a == alu_a);
        end
        step(alu_v, alu_a, int'($urandom), li_v, li_a, ld_v, ld_a, int'($urandom),
             $urandom_range(0, NUM_REGISTERS - 1));
    endtask

    // Monitor: every registered write is matched against the next expected one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                h_addr = 0;
                h_data = 0;
            end else if (write_enable) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", write_enable, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("write_cycle", cyc, e.cyc);
                    check("write_addr", write_addr, e.addr);
                    check("write_data", write_data, e.data);
                    h_addr = e.addr;
                    h_data = e.data;
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    check("missing_write", write_enable, 1);
                    void'(exp_q.pop_front());
                end
                check("hold_addr", write_addr, h_addr);
                check("hold_data", write_data, h_data);
            end
        end
    end

    initial begin
        rst = 1'b1;
        {alu_valid, ld_issue_valid, ld_done_valid} = '0;
        {alu_addr, ld_issue_addr, ld_done_addr, query_addr1, query_addr2} = '0;
        {alu_data, ld_data} = '0;
        do_reset();

        // Direct ALU write to r5.
        step(1, 5, 'h00ABCD, 0, 0, 0, 0, 0, 5);
        idle(2, 5);

        // Load return and ALU result collide; ALU is deferred one cycle.
        step(0, 0, 0, 1, 3, 0, 0, 0, 3);
        step(1, 4, 'h222222, 0, 0, 1, 3, 'h111111, 4);
        idle(3, 4);

        // Scoreboard: issue, return, then issue and return in the same cycle.
        step(0, 0, 0, 1, 7, 0, 0, 0, 7);
        idle(2, 7);
        step(0, 0, 0, 0, 0, 1, 7, 'h0A0707, 7);
        idle(1, 7);
        step(0, 0, 0, 1, 7, 0, 0, 0, 7);
        step(0, 0, 0, 1, 7, 1, 7, 'h0B0707, 7);
        idle(1, 7);
        step(0, 0, 0, 0, 0, 1, 7, 'h0C0707, 7);
        idle(2, 7);

        // Register 0 writes vanish, but a r0 load return still takes the slot.
        step(1, 0, 'h123456, 1, 0, 0, 0, 0, 0);
        step(1, 9, 'h090909, 0, 0, 1, 0, 'h654321, 0);
        idle(3, 9);

        // Fill the FIFO behind four load returns, overflow it, then drain.
        step(0, 0, 0, 1, 1, 0, 0, 0, 1);
        step(0, 0, 0, 1, 2, 0, 0, 0, 2);
        step(0, 0, 0, 1, 3, 0, 0, 0, 3);
        step(0, 0, 0, 1, 6, 0, 0, 0, 6);
        step(1, 8,  'hA00008, 0, 0, 1, 1, 'h100001, 8);
        step(1, 9,  'hB00009, 0, 0, 1, 2, 'h200002, 9);
        step(1, 10, 'hC0000A, 0, 0, 1, 3, 'h300003, 10);
        step(1, 11, 'hD0000B, 0, 0, 1, 6, 'h600006, 11);
        step(1, 12, 'hE0000C, 0, 0, 0, 0, 0, 12);
        idle(6, 12);

        // Reset with three deferred results in flight.
        step(0, 0, 0, 1, 1, 0, 0, 0, 1);
        step(0, 0, 0, 1, 2, 0, 0, 0, 2);
        step(0, 0, 0, 1, 3, 0, 0, 0, 3);
        step(1, 8,  'h000111, 0, 0, 1, 1, 'h000001, 8);
        step(1, 9,  'h000222, 0, 0, 1, 2, 'h000002, 9);
        step(1, 10, 'h000333, 0, 0, 1, 3, 'h000003, 10);
        do_reset();
        idle(4, 8);

        for (int i = 0; i < 1500; i++) rand_cycle();
        idle(8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

- Single-write-port arbiter feeding the register file's write port (`write_addr`/`write_data`/`write_enable`).
- Merges ALU results from the execute stage with late-returning load data.
- Buffers ALU results that lose arbitration in a small FIFO.
- Keeps a per-register scoreboard of outstanding loads; the hazard logic queries it for read-after-write and write-after-write stalls.

## Interface
- `REGFILE_ADDR_BITS`, 4, register index width (from params.v)
- `DATA_BUS_WIDTH`, 24, data width (from params.v)
- `NUM_REGISTERS`, 16, register count (from params.v)
- `WB_FIFO_DEPTH`, 4, deferred-ALU FIFO entries; power of two, at least 2

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `rst`  in  1  asynchronous, active-high reset
- `alu_valid`  in  1  ALU result present this cycle
- `alu_addr`  in  REGFILE_ADDR_BITS  ALU destination register
- `alu_data`  in  DATA_BUS_WIDTH  ALU result
- `ld_issue_valid`  in  1  load issued to memory this cycle
- `ld_issue_addr`  in  REGFILE_ADDR_BITS  load destination register
- `ld_done_valid`  in  1  load data returning this cycle
- `ld_done_addr`  in  REGFILE_ADDR_BITS  returning load destination
- `ld_data`  in  DATA_BUS_WIDTH  returning load data
- `query_addr1`, `query_addr2`  in  REGFILE_ADDR_BITS  hazard query addresses
- `busy1`, `busy2`  out  1  queried register has a write not yet emitted (combinational)
- `stall`  out  1  FIFO full; upstream must not assert `alu_valid`
- `overflow`  out  1  sticky; `alu_valid` arrived while full
- `write_addr`  out  REGFILE_ADDR_BITS  to register file
- `write_data`  out  DATA_BUS_WIDTH  to register file
- `write_enable`  out  1  to register file

## Operation
Each posedge selects at most one write, in priority order:
- **Load wins:** `ld_done_valid` is emitted. A concurrent `alu_valid` is pushed to the FIFO.
- **FIFO drains next:** otherwise, if the FIFO is non-empty, the head is emitted and popped. A concurrent `alu_valid` is pushed in the same cycle.
- **ALU direct:** otherwise, `alu_valid` is emitted directly without entering the FIFO.
- **Idle:** otherwise `write_enable` is 0. `write_addr` and `write_data` hold their last values.

Register 0 rules:
- An ALU or load write to register 0 is discarded: never pushed, never emitted.
- A load done for register 0 still consumes the load-priority slot.

Scoreboard (`pending[NUM_REGISTERS]`, bit 0 hard-wired 0):
- `ld_issue_valid` sets `pending[ld_issue_addr]`.
- `ld_done_valid` clears `pending[ld_done_addr]`.
- If the same register is set and cleared in one cycle, set wins.

Busy and hazard rules:
- `busyN` = (`query_addrN` ≠ 0) && (`pending[query_addrN]` || any valid FIFO entry has address `query_addrN`).
- Upstream must not issue an ALU op or load whose destination is busy. This preserves write ordering.

Overflow:
- `alu_valid` while `stall` is high drops the result and sets `overflow`.
- `overflow` clears only on reset.

## Timing
- **Reset:** `write_enable`=0, `write_addr`=0, `write_data`=0, FIFO empty, all `pending` 0, `stall`=0, `overflow`=0. Reset mid-operation discards FIFO contents and the scoreboard.
- **Latency:**
  - Direct ALU or load: outputs registered at the posedge that samples the inputs. The register file captures them at the following negedge.
  - Deferred ALU: one extra cycle per queued entry ahead of it, plus each cycle lost to a load.
- **Stall:** `stall` = (FIFO count == `WB_FIFO_DEPTH`), combinational from the count register.
- **FIFO pointers:** wrap modulo `WB_FIFO_DEPTH`. Simultaneous push and pop when full is not reachable, because the upstream honours `stall`.
- **Busy visibility:** `busy` drops in the cycle after the write is registered on the outputs.

## Structure
- Add `WB_FIFO_DEPTH` to params.v beside `REGFILE_ADDR_BITS`, `DATA_BUS_WIDTH` and `NUM_REGISTERS`.
- Sub-module `wb_fifo`:
  - Synchronous FIFO of {addr, data}.
  - Exposes count and a per-entry address-match vector for the two query ports.
- Top level holds the arbitration mux, output registers, scoreboard and overflow flag.

## Test plan
- **Reset:** assert `rst` mid-stream with FIFO at 3 entries -> all outputs 0, `busy1`/`busy2` 0 on any query, FIFO empty after release.
- **Direct ALU:** `alu_valid`, r5 = 0x00ABCD -> next cycle `write_enable`=1, `write_addr`=5, `write_data`=0x00ABCD.
- **Collision:** same-cycle `ld_done` r3 = 0x111111 and ALU r4 = 0x222222 -> cycle 1 writes r3, cycle 2 writes r4; `busy` for r4 high during cycle 1.
- **Scoreboard:** issue load r7 -> `busy` for r7 high; `ld_done` r7 -> write r7 and `busy` low the next cycle. Issue r7 and done r7 in the same cycle -> r7 remains pending.
- **Register 0:** ALU to r0 and load done to r0 -> `write_enable` never asserted, `busy` for r0 always 0.
- **Overflow:**
  - 4 loads completing back-to-back with 4 ALU results -> FIFO fills, `stall`=1.
  - A 5th `alu_valid` -> `overflow`=1, result dropped.
  - FIFO drains in order r-a, r-b, r-c, r-d.
